// File: rtl/pt_pixel_feeder_pkg.sv
// Shared constants and state encoding for the source-frame pixel feeder.
// Pure declarations, no latency.
// No flow control lives here.
package pt_pixel_feeder_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int PIX_W        = 18;
  localparam int ADDR_W       = 19;
  localparam int FIFO_DEPTH   = 8;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Pixel count of an h x v frame, sized to the address/counter width.
  function automatic logic [ADDR_W-1:0] frame_pixels(input int h, input int v);
    return ADDR_W'(h * v);
  endfunction

endpackage

// File: rtl/pt_pixel_feeder_if.sv
// Bundles the frame control, pixel service and memory read-port signals.
// Wires only, no latency.
// Flow control is request/ack on memory, request/flag on pixels.
interface pt_pixel_feeder_if;
  import pt_pixel_feeder_pkg::*;

  logic              frame_flag;
  logic [ADDR_W-1:0] base_addr;
  logic              request_pixel;
  logic [PIX_W-1:0]  pixel;
  logic              pixel_flag;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack;
  logic              mem_rd_valid;
  logic [PIX_W-1:0]  mem_rd_data;
  logic              frame_done;
  logic              busy;

  // Feeder side.
  modport master (
    input  frame_flag, base_addr, request_pixel, mem_rd_ack, mem_rd_valid, mem_rd_data,
    output pixel, pixel_flag, mem_rd_req, mem_rd_addr, frame_done, busy
  );

  // Environment side (arbiter, frame source, projective_transform).
  modport slave (
    output frame_flag, base_addr, request_pixel, mem_rd_ack, mem_rd_valid, mem_rd_data,
    input  pixel, pixel_flag, mem_rd_req, mem_rd_addr, frame_done, busy
  );

endinterface

// File: rtl/pt_pixel_feeder_pixel_fifo.sv
// Synchronous prefetch FIFO with flush and occupancy count.
// Head is visible combinationally; a push shows up one cycle later.
// Push when full and pop when empty are dropped; the caller's credit logic prevents both.
module pixel_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= dat_i;
  end

endmodule

// File: rtl/pt_pixel_feeder.sv
// Streams a source frame from memory in raster order into a prefetch FIFO and serves pixel requests.
// Pixel appears 1 cycle after a request when buffered, or 1 cycle after read data when pending.
// Reads are credit-limited to FIFO depth; one pending request is held while the FIFO is empty.
module pt_pixel_feeder
  import pt_pixel_feeder_pkg::*;
#(
  parameter int H_PIX   = H_ACTIVE,
  parameter int V_LINES = V_ACTIVE,
  parameter int DEPTH   = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  pt_pixel_feeder_if.master bus
);

  localparam int                CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] FRAME = frame_pixels(H_PIX, V_LINES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [ADDR_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [ADDR_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              pending_q, pending_d;
  logic              pix_flag_q, pix_flag_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [PIX_W-1:0]  fifo_head;
  logic              credit_ok, ack_ok, keep, bypass, want;

  pixel_fifo #(.WIDTH(PIX_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .dat_i   (bus.mem_rd_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Buffered plus in-flight words never exceed the FIFO size, so the FIFO cannot overflow.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < (CNT_W + 1)'(DEPTH);
  assign bus.mem_rd_req  = (state_q == ST_FETCH) && (fetch_cnt_q < FRAME) && credit_ok;
  assign bus.mem_rd_addr = bus.mem_rd_req ? (base_q + fetch_cnt_q) : '0;
  assign ack_ok = bus.mem_rd_req && bus.mem_rd_ack;
  // Returning words belong to the current frame only once every stale read is drained.
  assign keep   = bus.mem_rd_valid && (discard_q == '0);
  assign bypass = keep && pending_q && fifo_empty;
  assign want   = pending_q ||
                  (bus.request_pixel && (state_q != ST_IDLE) && (serve_cnt_q < FRAME));

  assign bus.pixel      = pix_q;
  assign bus.pixel_flag = pix_flag_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = busy_q;

  // Next-state: frame start/restart, fetch credit, stale-data discard and pixel service.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    fetch_cnt_d = fetch_cnt_q;
    serve_cnt_d = serve_cnt_q;
    discard_d   = discard_q;
    outst_d     = outst_q;
    pending_d   = pending_q;
    pix_flag_d  = 1'b0;
    pix_d       = pix_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    if (bus.frame_flag) begin
      // Every read still in flight, including one acked or returning now, is stale.
      state_d     = ST_FETCH;
      base_d      = bus.base_addr;
      fetch_cnt_d = '0;
      serve_cnt_d = '0;
      busy_d      = 1'b1;
      pending_d   = 1'b0;
      fifo_flush  = 1'b1;
      outst_d     = '0;
      discard_d   = discard_q + ADDR_W'(outst_q) + ADDR_W'(ack_ok) - ADDR_W'(bus.mem_rd_valid);
    end else begin
      if (ack_ok) fetch_cnt_d = fetch_cnt_q + ADDR_W'(1);
      if (bus.mem_rd_valid && (discard_q != '0)) discard_d = discard_q - ADDR_W'(1);
      outst_d   = outst_q + CNT_W'(ack_ok) - CNT_W'(keep);
      fifo_push = keep && !bypass;

      if (bypass) begin
        pix_d       = bus.mem_rd_data;
        pix_flag_d  = 1'b1;
        pending_d   = 1'b0;
        serve_cnt_d = serve_cnt_q + ADDR_W'(1);
      end else if (want && !fifo_empty) begin
        fifo_pop    = 1'b1;
        pix_d       = fifo_head;
        pix_flag_d  = 1'b1;
        pending_d   = 1'b0;
        serve_cnt_d = serve_cnt_q + ADDR_W'(1);
      end else if (want) begin
        pending_d = 1'b1;
      end

      case (state_q)
        ST_FETCH: if (ack_ok && (fetch_cnt_q == FRAME - ADDR_W'(1))) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (serve_cnt_q == FRAME) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            pending_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      fetch_cnt_q <= '0;
      serve_cnt_q <= '0;
      discard_q   <= '0;
      outst_q     <= '0;
      pending_q   <= 1'b0;
      pix_flag_q  <= 1'b0;
      pix_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      fetch_cnt_q <= fetch_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      discard_q   <= discard_d;
      outst_q     <= outst_d;
      pending_q   <= pending_d;
      pix_flag_q  <= pix_flag_d;
      pix_q       <= pix_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // A push into a full FIFO means the credit accounting is broken.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full));
  end

endmodule

// File: tb/tb_pt_pixel_feeder.sv
// Directed bench for pt_pixel_feeder on a reduced 16x4 frame with a latency-programmable memory model.
// A frame-level model checks pixels, requests, addresses, frame_done and busy every cycle.
// Per-scenario literal checks pin the model.
module tb_pt_pixel_feeder;
  import pt_pixel_feeder_pkg::*;

  localparam int H = 16;
  localparam int V = 4;
  localparam int FRAME = H * V;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pt_pixel_feeder_if bus ();

  pt_pixel_feeder #(.H_PIX(H), .V_LINES(V), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vecs = 0;
  int miscmp = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_pix(input int base, input int idx);
    logic [18:0] a;
    a = 19'(base + idx);
    return a[17:0];
  endfunction

  // ---------------- memory model: in-order returns after lat cycles, data = address[17:0]
  int cyc = 0;
  int lat = 2;
  int hold_cnt = 0;
  int          q_due [$];
  logic [18:0] q_addr [$];

  initial begin
    bus.mem_rd_ack   = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q_due.delete();
        q_addr.delete();
        bus.mem_rd_ack   = 1'b0;
        bus.mem_rd_valid = 1'b0;
      end else begin
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = q_addr[0][17:0];
          void'(q_due.pop_front());
          void'(q_addr.pop_front());
        end else begin
          bus.mem_rd_valid = 1'b0;
        end
        bus.mem_rd_ack = 1'b0;
        if (bus.mem_rd_req) begin
          if (hold_cnt > 0) hold_cnt--;
          else begin
            bus.mem_rd_ack = 1'b1;
            q_due.push_back(cyc + lat);
            q_addr.push_back(bus.mem_rd_addr);
          end
        end
      end
    end
  end

  // ---------------- frame-level model and per-cycle compare (1 time unit before the edge)
  bit   m_active = 0, m_done_next = 0;
  int   m_base = 0, m_fetch = 0, m_served = 0;
  int   flag_cnt = 0, done_cnt = 0, ack_cnt = 0;
  int   first_valid_cyc = -1, first_flag_cyc = -1;
  logic [17:0] first_pix = '1, last_pix = '1, pix_at32 = '1;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        m_active = 0; m_done_next = 0; m_fetch = 0; m_served = 0;
      end else begin
        if (m_done_next) m_active = 0;
        check("frame_done", bus.frame_done, m_done_next);
        if (bus.frame_done) done_cnt++;
        m_done_next = 0;
        check("busy", bus.busy, m_active);
        if (bus.pixel_flag) begin
          check("pixel_flag_allowed", (m_active && m_served < FRAME), 1'b1);
          check("pixel", bus.pixel, exp_pix(m_base, m_served));
          if (m_served == 0)  first_pix = bus.pixel;
          if (m_served == 32) pix_at32  = bus.pixel;
          last_pix = bus.pixel;
          m_served++;
          flag_cnt++;
          if (first_flag_cyc < 0) first_flag_cyc = cyc;
          if (m_served == FRAME) m_done_next = 1;
        end
        check("mem_rd_req", bus.mem_rd_req,
              (m_active && m_fetch < FRAME && (m_fetch - m_served) < DEPTH));
        if (bus.mem_rd_req && bus.mem_rd_ack) begin
          check("mem_rd_addr", bus.mem_rd_addr, 32'((m_base + m_fetch) & 32'h7ffff));
          m_fetch++;
          ack_cnt++;
        end
        if (bus.mem_rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.frame_flag) begin
          m_active = 1; m_base = 32'(bus.base_addr); m_fetch = 0; m_served = 0; m_done_next = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic clear_stats();
    flag_cnt = 0; done_cnt = 0; ack_cnt = 0;
    first_valid_cyc = -1; first_flag_cyc = -1;
    first_pix = '1; last_pix = '1; pix_at32 = '1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.frame_flag = 1'b0;
    bus.request_pixel = 1'b0;
    hold_cnt = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_frame(input logic [18:0] base);
    @(negedge clk);
    bus.frame_flag = 1'b1;
    bus.base_addr  = base;
    @(negedge clk);
    bus.frame_flag = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      #4;
      n++;
    end
    check(name, (done_cnt != 0), 1'b1);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pixel"},      bus.pixel, 0);
    check({tag, "_pixel_flag"}, bus.pixel_flag, 0);
    check({tag, "_req"},        bus.mem_rd_req, 0);
    check({tag, "_addr"},       bus.mem_rd_addr, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_busy"},       bus.busy, 0);
  endtask

  // ---------------- scenarios
  initial begin
    bus.frame_flag = 1'b0;
    bus.base_addr = '0;
    bus.request_pixel = 1'b0;
    #2;
    check_outputs_zero("reset");
    apply_reset();
    #4;
    check_outputs_zero("post_reset");

    // 1: full frame from base 0, request held high, latency 2
    lat = 2;
    clear_stats();
    bus.request_pixel = 1'b1;
    pulse_frame(19'h0);
    wait_done("t1_done_seen", 2000);
    repeat (3) @(negedge clk);
    #4;
    check("t1_flag_count", flag_cnt, FRAME);
    check("t1_done_count", done_cnt, 1);
    check("t1_first_pix", first_pix, 18'd0);
    check("t1_pix32", pix_at32, 18'd32);
    check("t1_last_pix", last_pix, 18'd63);
    check("t1_busy_low", bus.busy, 0);

    // 2+3: ack withheld 20 cycles, no requests, then one request
    apply_reset();
    clear_stats();
    lat = 2;
    hold_cnt = 20;
    pulse_frame(19'h0);
    for (int i = 0; i < 15; i++) begin
      #4;
      check("t2_req_held", bus.mem_rd_req, 1);
      check("t2_addr_held", bus.mem_rd_addr, 0);
      check("t2_no_ack", ack_cnt, 0);
      @(negedge clk);
    end
    repeat (85) @(negedge clk);
    #4;
    check("t3_reads_issued", ack_cnt, 8);
    check("t3_req_idle", bus.mem_rd_req, 0);
    @(negedge clk);
    bus.request_pixel = 1'b1;
    @(negedge clk);
    bus.request_pixel = 1'b0;
    #4;
    check("t3_flag", bus.pixel_flag, 1);
    check("t3_pixel", bus.pixel, 0);
    repeat (5) @(negedge clk);
    #4;
    check("t3_refill_read", ack_cnt, 9);
    check("t3_one_pulse", flag_cnt, 1);

    // 4: request pending on an empty FIFO, latency 10
    apply_reset();
    clear_stats();
    lat = 10;
    pulse_frame(19'h0);
    bus.request_pixel = 1'b1;
    @(negedge clk);
    bus.request_pixel = 1'b0;
    repeat (30) @(negedge clk);
    #4;
    check("t4_valid_seen", (first_valid_cyc > 0), 1);
    check("t4_flag_timing", first_flag_cyc, first_valid_cyc + 1);
    check("t4_one_pulse", flag_cnt, 1);
    check("t4_first_pix", first_pix, 18'd0);

    // 5: restart at base 0x1000 with reads in flight, latency 6
    apply_reset();
    clear_stats();
    lat = 6;
    pulse_frame(19'h0);
    for (int i = 0; i < 50 && ack_cnt < 2; i++) begin
      @(negedge clk);
      #4;
    end
    check("t5_inflight", (ack_cnt >= 2 && first_valid_cyc < 0), 1);
    @(negedge clk);
    clear_stats();
    bus.frame_flag = 1'b1;
    bus.base_addr  = 19'h01000;
    bus.request_pixel = 1'b1;
    @(negedge clk);
    bus.frame_flag = 1'b0;
    wait_done("t5_done_seen", 3000);
    repeat (3) @(negedge clk);
    #4;
    check("t5_first_pix", first_pix, 18'h01000);
    check("t5_flag_count", flag_cnt, FRAME);
    check("t5_done_count", done_cnt, 1);

    // 6: asynchronous reset mid-fetch, then a frame whose addresses wrap past the top
    apply_reset();
    clear_stats();
    lat = 2;
    bus.request_pixel = 1'b1;
    pulse_frame(19'h0);
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    pulse_frame(19'h7ffe0);
    wait_done("t6_done_seen", 2000);
    repeat (3) @(negedge clk);
    #4;
    check("t6_first_pix", first_pix, 18'h3ffe0);
    check("t6_wrap_pix", pix_at32, 18'h0);
    check("t6_flag_count", flag_cnt, FRAME);
    check("t6_done_count", done_cnt, 1);

    bus.request_pixel = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
